// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: command opcodes and FSM states.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_UP    = 2'b01,
    OP_DOWN  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/counter_sequencer.sv
// Command sequencer driving an external up/down counter: loads, clears and
// issues N count enables, optionally stopping at the counter's limits.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_value,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] steps_done,
  output logic             sat_hit
);

  localparam bit SatEn = (SATURATE != 0);

  state_e           state_q, state_d;
  logic             updn_q, updn_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  cmd_op_e          op;
  logic             limit;

  assign op    = cmd_op_e'(cmd_op);
  assign limit = updn_q ? (cnt_value == '1) : (cnt_value == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      updn_q  <= 1'b0;
      data_q  <= '0;
      steps_q <= '0;
      sat_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      updn_q  <= updn_d;
      data_q  <= data_d;
      steps_q <= steps_d;
      sat_q   <= sat_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    updn_d    = updn_q;
    data_d    = data_q;
    steps_d   = steps_q;
    sat_d     = sat_q;
    rem_d     = rem_q;
    ld_cnt    = 1'b1;
    count_enb = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (op)
            OP_LOAD: begin
              data_d  = cmd_value;
              state_d = ST_LOAD;
            end
            OP_CLEAR: begin
              data_d  = '0;
              state_d = ST_LOAD;
            end
            OP_UP, OP_DOWN: begin
              updn_d  = (op == OP_UP);
              steps_d = '0;
              sat_d   = 1'b0;
              rem_d   = cmd_value;
              state_d = (cmd_value == '0) ? ST_DONE : ST_RUN;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        ld_cnt  = 1'b0;
        state_d = ST_DONE;
      end
      ST_RUN: begin
        // Abort wins over the saturation limit, so sat_hit stays clear on abort.
        if (abort) begin
          state_d = ST_DONE;
        end else if (SatEn && limit) begin
          sat_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          count_enb = 1'b1;
          rem_d     = rem_q - WIDTH'(1);
          steps_d   = steps_q + WIDTH'(1);
          if (rem_q == WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign updn_cnt   = updn_q;
  assign data_in    = data_q;
  assign steps_done = steps_q;
  assign sat_hit    = sat_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a wrapping and a saturating instance share the
// command stream, each drives its own downstream counter model.
module tb_counter_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [15:0] cmd_value = 16'h0;
  logic abort = 1'b0;

  logic rdy0, ld0, updn0, enb0, busy0, done0, sat0;
  logic rdy1, ld1, updn1, enb1, busy1, done1, sat1;
  logic [15:0] din0, steps0, din1, steps1;
  logic [15:0] cnt0 = 16'h0;
  logic [15:0] cnt1 = 16'h0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(16), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
    .cmd_op(cmd_op), .cmd_value(cmd_value), .abort(abort), .cnt_value(cnt0),
    .ld_cnt(ld0), .updn_cnt(updn0), .count_enb(enb0), .data_in(din0),
    .busy(busy0), .done(done0), .steps_done(steps0), .sat_hit(sat0)
  );

  counter_sequencer #(.WIDTH(16), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_op(cmd_op), .cmd_value(cmd_value), .abort(abort), .cnt_value(cnt1),
    .ld_cnt(ld1), .updn_cnt(updn1), .count_enb(enb1), .data_in(din1),
    .busy(busy1), .done(done1), .steps_done(steps1), .sat_hit(sat1)
  );

  // Downstream counters (not reset by the sequencer's reset)
  always @(posedge clk) begin
    if (!ld0) cnt0 <= din0;
    else if (enb0) cnt0 <= updn0 ? cnt0 + 16'd1 : cnt0 - 16'd1;
    if (!ld1) cnt1 <= din1;
    else if (enb1) cnt1 <= updn1 ? cnt1 + 16'd1 : cnt1 - 16'd1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [38:0] q0[$];
  logic [38:0] q1[$];
  logic        h_updn [2];
  logic        h_sat  [2];
  logic [15:0] h_data [2];
  logic [15:0] h_steps[2];
  logic [15:0] mcnt   [2];

  function automatic logic [38:0] pk(input logic rdy, input logic bsy, input logic dn,
                                     input logic ld, input logic enb, input logic ud,
                                     input logic st, input logic [15:0] data,
                                     input logic [15:0] steps);
    return {rdy, bsy, dn, ld, enb, ud, st, data, steps};
  endfunction

  task automatic check(input string nm, input logic [38:0] act, input logic [38:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    check(nm, {23'b0, act}, {23'b0, exp});
  endtask

  task automatic push(input int inst, input logic [38:0] v);
    if (inst == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  // Expected per-cycle outputs for one accepted command, from cycle 0 after accept.
  task automatic model_cmd(input int inst, input logic [1:0] op, input logic [15:0] val,
                           input int abort_at);
    int n, lim, k;
    logic up, sat_fin;
    logic [15:0] v, start;
    if (op == 2'b00 || op == 2'b11) begin
      v = (op == 2'b00) ? val : 16'h0;
      push(inst, pk(0, 1, 0, 0, 0, h_updn[inst], h_sat[inst], v, h_steps[inst]));
      push(inst, pk(0, 1, 1, 1, 0, h_updn[inst], h_sat[inst], v, h_steps[inst]));
      h_data[inst] = v;
      mcnt[inst]   = v;
    end else begin
      up    = (op == 2'b01);
      n     = int'(val);
      start = mcnt[inst];
      lim   = (inst == 1) ? (up ? 65535 - int'(start) : int'(start)) : n;
      k = n;
      if (lim < k) k = lim;
      if (abort_at >= 0 && abort_at < k) k = abort_at;
      for (int i = 0; i < k; i++)
        push(inst, pk(0, 1, 0, 1, 1, up, 0, h_data[inst], 16'(i)));
      sat_fin = (k < n) && (abort_at != k);
      if (k < n) push(inst, pk(0, 1, 0, 1, 0, up, 0, h_data[inst], 16'(k)));
      push(inst, pk(0, 1, 1, 1, 0, up, sat_fin, h_data[inst], 16'(k)));
      h_updn[inst]  = up;
      h_steps[inst] = 16'(k);
      h_sat[inst]   = sat_fin;
      mcnt[inst]    = up ? start + 16'(k) : start - 16'(k);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      h_updn[i] = 0; h_sat[i] = 0; h_data[i] = 0; h_steps[i] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Called at posedge+1 of an idle cycle; returns at posedge+1 of the next idle cycle.
  task automatic send(input logic [1:0] op, input logic [15:0] val, input int abort_at);
    int c;
    cmd_op = op; cmd_value = val; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_cmd(0, op, val, abort_at);
    model_cmd(1, op, val, abort_at);
    c = 0;
    while ((q0.size() != 0 || q1.size() != 0) && c < 300) begin
      abort = (c == abort_at);
      @(posedge clk); #1;
      c++;
    end
    abort = 1'b0;
    if (c >= 300) check("cmd_timeout", 39'd1, 39'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [38:0] e0, e1;
      e0 = (q0.size() != 0) ? q0.pop_front()
         : pk(1, 0, 0, 1, 0, h_updn[0], h_sat[0], h_data[0], h_steps[0]);
      e1 = (q1.size() != 0) ? q1.pop_front()
         : pk(1, 0, 0, 1, 0, h_updn[1], h_sat[1], h_data[1], h_steps[1]);
      check("cyc_wrap", pk(rdy0, busy0, done0, ld0, enb0, updn0, sat0, din0, steps0), e0);
      check("cyc_sat",  pk(rdy1, busy1, done1, ld1, enb1, updn1, sat1, din1, steps1), e1);
    end
  end

  initial begin
    model_reset();
    mcnt[0] = 0; mcnt[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_wrap", pk(rdy0, busy0, done0, ld0, enb0, updn0, sat0, din0, steps0),
          pk(1, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0));
    check("rst_out_sat", pk(rdy1, busy1, done1, ld1, enb1, updn1, sat1, din1, steps1),
          pk(1, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0));
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // LOAD with abort held during the LOAD cycle (must be ignored)
    send(2'b00, 16'h1234, 0);
    chk16("load_cnt", cnt0, 16'h1234);
    send(2'b01, 16'd5, -1);
    chk16("up5_cnt", cnt0, 16'h1239);
    chk16("up5_steps", steps0, 16'd5);
    send(2'b10, 16'd0, -1);
    chk16("down0_cnt", cnt1, 16'h1239);
    chk16("down0_steps", steps1, 16'd0);

    send(2'b00, 16'hFFFD, -1);
    send(2'b01, 16'd10, -1);
    chk16("sat_up_cnt", cnt1, 16'hFFFF);
    chk16("sat_up_hit", {15'b0, sat1}, 16'd1);
    chk16("sat_up_steps", steps1, 16'd2);
    chk16("wrap_up_cnt", cnt0, 16'h0007);
    chk16("wrap_up_steps", steps0, 16'd10);
    send(2'b10, 16'd3, -1);
    chk16("sat_clr_hit", {15'b0, sat1}, 16'd0);
    chk16("sat_down_cnt", cnt1, 16'hFFFC);

    send(2'b11, 16'hBEEF, -1);
    send(2'b10, 16'd5, -1);
    chk16("sat_zero_hit", {15'b0, sat1}, 16'd1);
    chk16("wrap_down_cnt", cnt0, 16'hFFFB);

    // Abort coinciding with the saturation limit leaves sat_hit clear
    send(2'b00, 16'hFFFF, -1);
    send(2'b01, 16'd5, 0);
    chk16("abort_lim_hit", {15'b0, sat1}, 16'd0);
    chk16("abort_lim_steps", steps1, 16'd0);

    send(2'b00, 16'h0000, -1);
    send(2'b01, 16'd100, 3);
    chk16("abort3_steps", steps0, 16'd3);
    chk16("abort3_cnt", cnt0, 16'd3);

    // Reset between clock edges in the middle of a run
    cmd_op = 2'b01; cmd_value = 16'd100; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk16("run_enb", {15'b0, enb0}, 16'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_wrap", pk(rdy0, busy0, done0, ld0, enb0, updn0, sat0, din0, steps0),
          pk(1, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0));
    check("midrst_sat", pk(rdy1, busy1, done1, ld1, enb1, updn1, sat1, din1, steps1),
          pk(1, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    @(posedge clk); #1;
    send(2'b11, 16'h0, -1);
    chk16("clear_cnt", cnt0, 16'h0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, width of counter value, load value and step count.
REQ-002 Parameter: SATURATE, 0, 1 = stop an UP at all-ones / DOWN at zero instead of wrapping.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted on edge where cmd_valid && cmd_ready.
REQ-007 cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
REQ-008 cmd_value  in  WIDTH  load value (LOAD) or step count N (UP/DOWN); ignored for CLEAR.
REQ-009 abort  in  1  terminate a running UP/DOWN.
REQ-010 cnt_value  in  WIDTH  downstream counter's current output (feedback).
REQ-011 ld_cnt  out  1  active-low load strobe to counter.
REQ-012 updn_cnt  out  1  direction to counter, 1 = up.
REQ-013 count_enb  out  1  count enable to counter.
REQ-014 data_in  out  WIDTH  load value to counter.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 steps_done  out  WIDTH  count_enb cycles issued by last command.
REQ-018 sat_hit  out  1  last UP/DOWN stopped at a saturation limit.

Function
REQ-019 FSM states IDLE, LOAD, RUN, DONE; cmd_ready = (state == IDLE).
REQ-020 On accept: LOAD -> capture cmd_value into data_in, go LOAD; CLEAR -> data_in = 0, go LOAD.
REQ-021 On accept: UP/DOWN -> register updn_cnt (UP=1, DOWN=0), clear steps_done and sat_hit, load remaining = N; N == 0 goes to DONE, else RUN.
REQ-022 LOAD state lasts exactly one cycle with ld_cnt = 0, count_enb = 0; next state DONE.
REQ-023 RUN: count_enb combinational = !abort && !(SATURATE && limit), where limit = (cnt_value == all-ones for up, == 0 for down).
REQ-024 RUN with count_enb = 1: remaining decrements, steps_done increments; remaining == 1 -> DONE; hence N enables in N consecutive cycles.
REQ-025 RUN with limit (SATURATE = 1): count_enb = 0, sat_hit set, next state DONE.
REQ-026 RUN with abort: count_enb = 0, next state DONE; abort has priority over limit for sat_hit (sat_hit not set); abort ignored outside RUN.
REQ-027 SATURATE = 0: counter wraps modulo 2^WIDTH; sequencer never inspects cnt_value.
REQ-028 DONE lasts one cycle with done = 1, then IDLE; a new command is accepted no earlier than the cycle after DONE.
REQ-029 ld_cnt = 1 and count_enb = 0 in IDLE, DONE; ld_cnt and count_enb are never active in the same cycle.
REQ-030 updn_cnt, data_in, steps_done, sat_hit hold their values until the next accepted command that updates them.

Reset
REQ-031 rst high forces immediately: state IDLE, ld_cnt = 1, count_enb = 0, updn_cnt = 0, data_in = 0, busy = 0, done = 0, steps_done = 0, sat_hit = 0, remaining = 0.
REQ-032 cmd_ready = 1 from first edge after rst deasserts; reset mid-RUN discards the command with no done pulse.

Structure
REQ-033 Package counter_seq_pkg holds the cmd_op enum (LOAD/UP/DOWN/CLEAR) and the FSM state enum.
REQ-034 Single module; no sub-module; remaining/steps_done counters inline.

Verification
REQ-035 LOAD 16'h1234 -> ld_cnt low one cycle with data_in = 16'h1234, done next cycle, counter reads 16'h1234.
REQ-036 UP N = 5 from 16'h1234 -> count_enb high 5 consecutive cycles, updn_cnt = 1, counter 16'h1239, steps_done = 5.
REQ-037 DOWN N = 0 -> no count_enb, done one cycle after accept, steps_done = 0, counter unchanged.
REQ-038 SATURATE = 1, LOAD 16'hFFFD then UP N = 10 -> 2 enables, counter 16'hFFFF, sat_hit = 1, steps_done = 2.
REQ-039 UP N = 100, abort after 3 enables -> count_enb low in abort cycle, done next, steps_done = 3.
REQ-040 rst pulse mid-RUN (between edges) -> count_enb drops without clock, busy = 0, no done; next CLEAR accepted normally.
